// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM between the pixel-fetch path (strict priority)
// and the collision-lookup path. Define COL_STALL_STATS_EN to add col_stall_cnt.
module sprite_rom_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              col_req,
  input  logic [ADDR_W-1:0] col_addr,
  output logic              col_gnt,
  output logic [DATA_W-1:0] col_data,
  output logic              col_valid,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_q
`ifdef COL_STALL_STATS_EN
  , output logic [15:0]     col_stall_cnt
`endif
);

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_PEND = 2'd1, C_BUSY = 2'd2} col_st_e;
  typedef struct packed { logic vld; logic col; } tag_t;

  col_st_e           st_q, st_d;
  logic              col_issue;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rom_rd_q, rom_rd_d;
  tag_t [ROM_LAT:0]  tag_pipe_q, tag_pipe_d;
  tag_t              tag_out;
  logic [DATA_W-1:0] pix_data_q, pix_data_d, col_data_q, col_data_d;
  logic              pix_valid_q, pix_valid_d, col_valid_q, col_valid_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) st_q <= C_IDLE;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      C_IDLE:  if (col_req) st_d = pix_req ? C_PEND : C_BUSY;
      C_PEND:  if (!col_req) st_d = C_IDLE;
               else if (!pix_req) st_d = C_BUSY;
      C_BUSY:  if (col_valid_q) st_d = C_IDLE;
      default: st_d = C_IDLE;
    endcase
  end

  always_comb begin
    col_issue = col_req && !pix_req && (st_q == C_IDLE || st_q == C_PEND);
    col_gnt   = col_issue;
  end

  // Tag stage ROM_LAT lines up with rom_q; data/valid are registered one cycle later.
  always_comb begin
    rom_rd_d   = pix_req | col_issue;
    rom_addr_d = rom_addr_q;
    if (pix_req)        rom_addr_d = pix_addr;
    else if (col_issue) rom_addr_d = col_addr;
    tag_pipe_d[0].vld = rom_rd_d;
    tag_pipe_d[0].col = ~pix_req;
    for (int i = 1; i <= ROM_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
    tag_out     = tag_pipe_q[ROM_LAT];
    pix_valid_d = tag_out.vld & ~tag_out.col;
    col_valid_d = tag_out.vld &  tag_out.col;
    pix_data_d  = pix_valid_d ? rom_q : pix_data_q;
    col_data_d  = col_valid_d ? rom_q : col_data_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q  <= '0;
      rom_rd_q    <= 1'b0;
      tag_pipe_q  <= '0;
      pix_data_q  <= '0;
      col_data_q  <= '0;
      pix_valid_q <= 1'b0;
      col_valid_q <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      rom_rd_q    <= rom_rd_d;
      tag_pipe_q  <= tag_pipe_d;
      pix_data_q  <= pix_data_d;
      col_data_q  <= col_data_d;
      pix_valid_q <= pix_valid_d;
      col_valid_q <= col_valid_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_rd    = rom_rd_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign col_data  = col_data_q;
  assign col_valid = col_valid_q;

`ifdef COL_STALL_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts every cycle that ends parked in C_PEND, including the entry cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (col_issue)
      stall_cnt_d = '0;
    else if (st_d == C_PEND && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign col_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: behavioural ROM, per-owner scoreboards checked on
// every valid pulse, a per-cycle grant table, and hand sequences for corner cases.
module tb_sprite_rom_arbiter;
  localparam int AW = 12, DW = 8, LAT = 1;

  logic          Clk = 1'b0, Reset_n = 1'b0;
  logic          pix_req = 1'b0, col_req = 1'b0;
  logic [AW-1:0] pix_addr = '0, col_addr = '0;
  logic [DW-1:0] pix_data, col_data;
  logic          pix_valid, col_valid, col_gnt, rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q = '0;
`ifdef COL_STALL_STATS_EN
  logic [15:0]   col_stall_cnt;
`endif

  sprite_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data), .pix_valid(pix_valid),
    .col_req(col_req), .col_addr(col_addr), .col_gnt(col_gnt),
    .col_data(col_data), .col_valid(col_valid),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q)
`ifdef COL_STALL_STATS_EN
    , .col_stall_cnt(col_stall_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] rom_mem [0:4095];
  always @(posedge Clk) if (rom_rd) rom_q <= rom_mem[rom_addr];

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t pix_exp[$], col_exp[$];
  exp_t me;
  int cyc = 0, n_pass = 0, n_chk = 0, pix_valid_cnt = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard side: col expectation is known once the grant shows; pix at drive time.
  always @(negedge Clk) if (Reset_n) begin
    if (col_gnt) col_exp.push_back('{rom_mem[col_addr], cyc + 2 + LAT});
    if (pix_valid) begin
      pix_valid_cnt++;
      if (pix_exp.size() == 0) chk("pix_spurious_valid", 32'd1, 32'd0);
      else begin
        me = pix_exp.pop_front();
        chk("pix_data", 32'(pix_data), 32'(me.data));
        chk("pix_latency", cyc, me.due);
      end
    end
    if (col_valid) begin
      if (col_exp.size() == 0) chk("col_spurious_valid", 32'd1, 32'd0);
      else begin
        me = col_exp.pop_front();
        chk("col_data", 32'(col_data), 32'(me.data));
        chk("col_latency", cyc, me.due);
      end
    end
  end

  task automatic drive(input logic p, input logic [AW-1:0] pa, input logic c, input logic [AW-1:0] ca);
    @(posedge Clk); #1;
    pix_req = p; pix_addr = pa; col_req = c; col_addr = ca;
    if (p) pix_exp.push_back('{rom_mem[pa], cyc + 2 + LAT});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0);
  endtask

  typedef struct { logic p; logic [AW-1:0] pa; logic c; logic [AW-1:0] ca; logic gnt; } vec_t;
  vec_t tbl [17];

  initial begin
    int gnts, k, pv0;
    for (int a = 0; a < 4096; a++) rom_mem[a] = 8'(a * 37 + 11) ^ 8'(a >> 4);
    rom_mem[12'h010] = 8'h5A;
    rom_mem[12'h123] = 8'h77;

    tbl[0]  = '{1'b1, 12'h010, 1'b0, 12'h000, 1'b0};
    tbl[1]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[2]  = '{1'b0, 12'h000, 1'b1, 12'h123, 1'b1};
    tbl[3]  = '{1'b1, 12'h200, 1'b0, 12'h000, 1'b0};
    tbl[4]  = '{1'b1, 12'h201, 1'b0, 12'h000, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[6]  = '{1'b1, 12'h300, 1'b1, 12'h456, 1'b0};
    tbl[7]  = '{1'b1, 12'h301, 1'b1, 12'h456, 1'b0};
    tbl[8]  = '{1'b0, 12'h000, 1'b1, 12'h456, 1'b1};
    tbl[9]  = '{1'b0, 12'h000, 1'b1, 12'h789, 1'b0};
    tbl[10] = '{1'b0, 12'h000, 1'b1, 12'h789, 1'b0};
    tbl[11] = '{1'b0, 12'h000, 1'b1, 12'h789, 1'b0};
    tbl[12] = '{1'b0, 12'h000, 1'b1, 12'h789, 1'b1};
    tbl[13] = '{1'b1, 12'hFFF, 1'b0, 12'h000, 1'b0};
    tbl[14] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[15] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[16] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outputs", {pix_data, pix_valid, col_data, col_valid, rom_addr, rom_rd, col_gnt}, 32'd0);
    @(posedge Clk); #1 Reset_n = 1'b1;

    // First pixel read: strobe one cycle after issue, data via scoreboard at N+3.
    drive(1'b1, 12'h010, 1'b0, '0);
    drive(1'b0, '0, 1'b0, '0);
    @(negedge Clk);
    chk("rom_rd_n1", 32'(rom_rd), 32'd1);
    chk("rom_addr_n1", 32'(rom_addr), 32'h010);
    idle(3);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].p, tbl[i].pa, tbl[i].c, tbl[i].ca);
      @(negedge Clk);
      chk($sformatf("tbl%0d_gnt", i), 32'(col_gnt), 32'(tbl[i].gnt));
    end
    idle(4);

    // Starvation: 20 pixel cycles with collision pending, grant on the 21st.
    gnts = 0;
    pv0 = pix_valid_cnt;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, AW'(12'h400 + i), 1'b1, 12'h5AB);
      @(negedge Clk);
      if (col_gnt) gnts++;
    end
    chk("starve_no_gnt", gnts, 0);
    drive(1'b0, '0, 1'b1, 12'h5AB);
    @(negedge Clk);
`ifdef COL_STALL_STATS_EN
    chk("stall_cnt_before_gnt", 32'(col_stall_cnt), 32'd20);
`endif
    chk("starve_gnt21", 32'(col_gnt), 32'd1);
    drive(1'b0, '0, 1'b0, '0);
    @(negedge Clk);
`ifdef COL_STALL_STATS_EN
    chk("stall_cnt_after_gnt", 32'(col_stall_cnt), 32'd0);
`endif
    idle(4);
    chk("starve_pix_valids", pix_valid_cnt - pv0, 20);

    // Cancel while pending: no grant, and the FSM is idle again afterwards.
    drive(1'b1, 12'h0A0, 1'b1, 12'h0B0);
    @(negedge Clk);
    chk("pend_gnt0", 32'(col_gnt), 32'd0);
    gnts = 0;
    repeat (6) begin
      drive(1'b0, '0, 1'b0, '0);
      @(negedge Clk);
      if (col_gnt) gnts++;
    end
    chk("cancel_no_gnt", gnts, 0);
    drive(1'b0, '0, 1'b1, 12'h0B1);
    @(negedge Clk);
    chk("idle_after_cancel_gnt", 32'(col_gnt), 32'd1);
    idle(5);

    // Reset one cycle after a pixel issue drops the read.
    drive(1'b1, 12'h0C0, 1'b0, '0);
    @(posedge Clk); #1;
    Reset_n = 1'b0; pix_req = 1'b0; pix_addr = '0;
    pix_exp.delete(); col_exp.delete();
    @(negedge Clk);
    chk("reset_mid_outputs", {pix_data, pix_valid, col_data, col_valid, rom_addr, rom_rd, col_gnt}, 32'd0);
    @(posedge Clk); #1 Reset_n = 1'b1;
    idle(4);
    drive(1'b1, 12'h010, 1'b0, '0);
    idle(4);

    k = 0;
    while ((pix_exp.size() != 0 || col_exp.size() != 0) && k < 20) begin
      @(posedge Clk);
      k++;
    end
    chk("drain_pix", pix_exp.size(), 0);
    chk("drain_col", col_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
